// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Brief    : Multi-cycle HI/LO multiply/divide unit (mult/multu/div/divu,
//             mthi/mtlo). Divider present only when MD_DIV_EN is defined.
//  Revision : 1.0
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mult = 2'd1;

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;
`ifdef MD_DIV_EN
    localparam logic [1:0]         c_st_div   = 2'd2;
    localparam logic [2:0]         c_op_div   = 3'd3;
    localparam logic [2:0]         c_op_divu  = 3'd4;
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_CYCLES);
`endif

    logic [1:0]         state_q, state_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;

    // Sign-extending only for signed ops lets one 64-bit multiplier serve both.
    logic [63:0] w_prod;
    assign w_prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

`ifdef MD_DIV_EN
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_mag_a, w_mag_b, w_uquo, w_urem, w_quo, w_rem;

    // Divide magnitudes then fix signs; this also makes 0x80000000 / -1 wrap cleanly.
    always_comb begin
        w_neg_a = sgn_q & a_q[31];
        w_neg_b = sgn_q & b_q[31];
        w_mag_a = w_neg_a ? (32'd0 - a_q) : a_q;
        w_mag_b = w_neg_b ? (32'd0 - b_q) : b_q;
        w_uquo  = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
        w_urem  = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);
        w_quo   = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uquo) : w_uquo;
        w_rem   = w_neg_a ? (32'd0 - w_urem) : w_urem;
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    case (md_op)
                        c_op_mult, c_op_multu: begin
                            a_d     = a;
                            b_d     = b;
                            sgn_d   = (md_op == c_op_mult);
                            count_d = c_mult_load;
                            state_d = c_st_mult;
                        end
`ifdef MD_DIV_EN
                        c_op_div, c_op_divu: begin
                            a_d     = a;
                            b_d     = b;
                            sgn_d   = (md_op == c_op_div);
                            count_d = c_div_load;
                            state_d = c_st_div;
                        end
`endif
                        c_op_mthi: hi_d = a;
                        c_op_mtlo: lo_d = a;
                        default: ;
                    endcase
                end
            end
            c_st_mult: begin
                count_d = count_q - c_cnt_one;
                if (count_q == c_cnt_one) begin
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    state_d = c_st_idle;
                end
            end
`ifdef MD_DIV_EN
            c_st_div: begin
                count_d = count_q - c_cnt_one;
                if (count_q == c_cnt_one) begin
                    if (b_q != 32'd0) begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end
                    state_d = c_st_idle;
                end
            end
`endif
            default: state_d = c_st_idle;
        endcase
        busy_d = (state_d != c_st_idle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_st_idle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
